// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the multicycle RISC-V control unit.
package riscv_ctrl_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned XIMM_W   = 3;

    localparam bit          DEF_SUPPORT_JALR = 1'b1;
    localparam bit          DEF_SUPPORT_LUI  = 1'b1;
    localparam int unsigned DEF_CNT_W        = 32;

    localparam logic [OPCODE_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_JAL  = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JALR = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_LUI  = 7'b0110111;

    localparam logic [SEL_W-1:0] ASEL_PC     = 2'b00;
    localparam logic [SEL_W-1:0] ASEL_OLDPC  = 2'b01;
    localparam logic [SEL_W-1:0] ASEL_RS1    = 2'b10;
    localparam logic [SEL_W-1:0] ASEL_ZERO   = 2'b11;

    localparam logic [SEL_W-1:0] BSEL_RS2    = 2'b00;
    localparam logic [SEL_W-1:0] BSEL_XIMM   = 2'b01;
    localparam logic [SEL_W-1:0] BSEL_FOUR   = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] RES_ALUOUT  = 2'b00;
    localparam logic [SEL_W-1:0] RES_RDATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU     = 2'b10;

    localparam logic [XIMM_W-1:0] XIMM_I = 3'b000;
    localparam logic [XIMM_W-1:0] XIMM_S = 3'b001;
    localparam logic [XIMM_W-1:0] XIMM_B = 3'b010;
    localparam logic [XIMM_W-1:0] XIMM_J = 3'b011;
    localparam logic [XIMM_W-1:0] XIMM_U = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_JAL, S_BEQ, S_JALR_ADR, S_JALR,
        S_LUI, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_LW, CLS_SW, CLS_R, CLS_I, CLS_JAL, CLS_BEQ, CLS_JALR, CLS_LUI,
        CLS_ILLEGAL
    } instr_class_t;

endpackage

// File: rtl/ctrl_opcode_classifier.sv
// Maps the IR opcode to an instruction class and immediate format.
module ctrl_opcode_classifier
    import riscv_ctrl_pkg::*;
#(
    parameter bit SUPPORT_JALR = DEF_SUPPORT_JALR,
    parameter bit SUPPORT_LUI  = DEF_SUPPORT_LUI
) (
    input  logic [OPCODE_W-1:0] opcode,
    output instr_class_t        instr_class,
    output logic [XIMM_W-1:0]   ximm_sel
);

    // Disabled optional opcodes fall through as illegal with the default format.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        ximm_sel    = XIMM_I;
        case (opcode)
            OP_LW:   begin instr_class = CLS_LW;  ximm_sel = XIMM_I; end
            OP_SW:   begin instr_class = CLS_SW;  ximm_sel = XIMM_S; end
            OP_R:    begin instr_class = CLS_R;   ximm_sel = XIMM_I; end
            OP_I:    begin instr_class = CLS_I;   ximm_sel = XIMM_I; end
            OP_JAL:  begin instr_class = CLS_JAL; ximm_sel = XIMM_J; end
            OP_BEQ:  begin instr_class = CLS_BEQ; ximm_sel = XIMM_B; end
            OP_JALR: begin
                if (SUPPORT_JALR) begin
                    instr_class = CLS_JALR;
                    ximm_sel    = XIMM_I;
                end
            end
            OP_LUI: begin
                if (SUPPORT_LUI) begin
                    instr_class = CLS_LUI;
                    ximm_sel    = XIMM_U;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V core with memory handshake,
// sticky illegal-opcode trap and retired-instruction counter.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit          SUPPORT_JALR = DEF_SUPPORT_JALR,
    parameter bit          SUPPORT_LUI  = DEF_SUPPORT_LUI,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                adr_sel,
    output logic                ir_wren,
    output logic                pc_update,
    output logic                branch,
    output logic                mem_wren,
    output logic                regfile_wren,
    output logic [SEL_W-1:0]    alu_asel,
    output logic [SEL_W-1:0]    alu_bsel,
    output logic [SEL_W-1:0]    alu_op,
    output logic [SEL_W-1:0]    result_sel,
    output logic [XIMM_W-1:0]   ximm_sel,
    output logic                retire,
    output logic                illegal_instr,
    output logic [CNT_W-1:0]    retire_count
);

    state_t       state;
    state_t       next_state;
    instr_class_t instr_class;

    ctrl_opcode_classifier #(
        .SUPPORT_JALR (SUPPORT_JALR),
        .SUPPORT_LUI  (SUPPORT_LUI)
    ) u_classifier (
        .opcode      (opcode),
        .instr_class (instr_class),
        .ximm_sel    (ximm_sel)
    );

    // State register; reset returns to FETCH, abandoning any instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= next_state;
    end

    // Next-state logic; memory states hold until mem_ready.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (instr_class)
                    CLS_LW, CLS_SW: next_state = S_MEMADR;
                    CLS_R:          next_state = S_EXEC_R;
                    CLS_I:          next_state = S_EXEC_I;
                    CLS_JAL:        next_state = S_JAL;
                    CLS_BEQ:        next_state = S_BEQ;
                    CLS_JALR:       next_state = S_JALR_ADR;
                    CLS_LUI:        next_state = S_LUI;
                    default:        next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state = (instr_class == CLS_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXEC_R:   next_state = S_ALUWB;
            S_EXEC_I:   next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_BEQ:      next_state = S_FETCH;
            S_JALR_ADR: next_state = S_JALR;
            S_JALR:     next_state = S_ALUWB;
            S_LUI:      next_state = S_ALUWB;
            S_TRAP:     next_state = S_TRAP;
            default:    next_state = S_FETCH;
        endcase
    end

    // Per-state datapath controls; strobes are squashed while reset is low.
    always_comb begin
        mem_req      = 1'b0;
        adr_sel      = 1'b0;
        ir_wren      = 1'b0;
        pc_update    = 1'b0;
        branch       = 1'b0;
        mem_wren     = 1'b0;
        regfile_wren = 1'b0;
        alu_asel     = ASEL_PC;
        alu_bsel     = BSEL_RS2;
        alu_op       = ALUOP_ADD;
        result_sel   = RES_ALUOUT;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                ir_wren    = mem_ready;
                pc_update  = mem_ready;
                alu_asel   = ASEL_PC;
                alu_bsel   = BSEL_FOUR;
                result_sel = RES_ALU;
            end
            S_DECODE: begin
                alu_asel = ASEL_OLDPC;
                alu_bsel = BSEL_XIMM;
            end
            S_MEMADR, S_JALR_ADR: begin
                alu_asel = ASEL_RS1;
                alu_bsel = BSEL_XIMM;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_sel = 1'b1;
            end
            S_MEMWB: begin
                result_sel   = RES_RDATA;
                regfile_wren = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                adr_sel  = 1'b1;
                mem_wren = mem_ready;
            end
            S_EXEC_R: begin
                alu_asel = ASEL_RS1;
                alu_bsel = BSEL_RS2;
                alu_op   = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_asel = ASEL_RS1;
                alu_bsel = BSEL_XIMM;
                alu_op   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                result_sel   = RES_ALUOUT;
                regfile_wren = 1'b1;
            end
            S_JAL, S_JALR: begin
                alu_asel  = ASEL_OLDPC;
                alu_bsel  = BSEL_FOUR;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                alu_asel = ASEL_RS1;
                alu_bsel = BSEL_RS2;
                alu_op   = ALUOP_SUB;
                branch   = 1'b1;
            end
            S_LUI: begin
                alu_asel = ASEL_ZERO;
                alu_bsel = BSEL_XIMM;
            end
            default: ;
        endcase
        if (!rst_n) begin
            mem_req      = 1'b0;
            ir_wren      = 1'b0;
            pc_update    = 1'b0;
            branch       = 1'b0;
            mem_wren     = 1'b0;
            regfile_wren = 1'b0;
        end
        retire = rst_n && (state != S_FETCH) && (next_state == S_FETCH);
    end

    // Sticky trap flag, set as DECODE hands off to TRAP.
    always_ff @(posedge clk) begin
        if (!rst_n)                    illegal_instr <= 1'b0;
        else if (next_state == S_TRAP) illegal_instr <= 1'b1;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n)      retire_count <= '0;
        else if (retire) retire_count <= retire_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: default build plus a
// SUPPORT_LUI=0 / CNT_W=4 build for the trap and wrap scenarios.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;
    localparam logic [2:0] XI = 3'b000;
    localparam logic [2:0] XS = 3'b001;
    localparam logic [2:0] XB = 3'b010;
    localparam logic [2:0] XJ = 3'b011;

    // Control vector {mem_req,adr_sel,ir_wren,pc_update,branch,mem_wren,
    // regfile_wren,retire, asel,bsel,alu_op,result_sel}
    localparam logic [15:0] V_RST    = 16'h0022;
    localparam logic [15:0] V_FET_W  = 16'h8022;
    localparam logic [15:0] V_FET    = 16'hB022;
    localparam logic [15:0] V_DEC    = 16'h0050;
    localparam logic [15:0] V_MADR   = 16'h0090;
    localparam logic [15:0] V_MREQ   = 16'hC000;
    localparam logic [15:0] V_MWB    = 16'h0301;
    localparam logic [15:0] V_MWR    = 16'hC500;
    localparam logic [15:0] V_EXR    = 16'h0088;
    localparam logic [15:0] V_ALUWB  = 16'h0300;
    localparam logic [15:0] V_JAL    = 16'h1060;
    localparam logic [15:0] V_BEQ    = 16'h0984;
    localparam logic [15:0] V_TRAP   = 16'h0000;

    logic clk = 1'b0;
    logic rst_n, mem_ready;
    logic [6:0] opcode;
    logic mem_req, adr_sel, ir_wren, pc_update, branch, mem_wren, regfile_wren;
    logic [1:0] alu_asel, alu_bsel, alu_op, result_sel;
    logic [2:0] ximm_sel;
    logic retire, illegal_instr;
    logic [31:0] retire_count;

    logic rst_b, ready_b;
    logic [6:0] opcode_b;
    logic b_mem_req, b_adr_sel, b_ir_wren, b_pc_update, b_branch, b_mem_wren, b_regfile_wren;
    logic [1:0] b_asel, b_bsel, b_alu_op, b_result_sel;
    logic [2:0] b_ximm_sel;
    logic b_retire, b_illegal;
    logic [3:0] b_count;

    int total = 0;
    int bad   = 0;

    logic [18:0] obs;
    logic [15:0] obs_b;
    assign obs   = {ximm_sel, mem_req, adr_sel, ir_wren, pc_update, branch, mem_wren,
                    regfile_wren, retire, alu_asel, alu_bsel, alu_op, result_sel};
    assign obs_b = {b_mem_req, b_adr_sel, b_ir_wren, b_pc_update, b_branch, b_mem_wren,
                    b_regfile_wren, b_retire, b_asel, b_bsel, b_alu_op, b_result_sel};

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .adr_sel(adr_sel), .ir_wren(ir_wren), .pc_update(pc_update),
        .branch(branch), .mem_wren(mem_wren), .regfile_wren(regfile_wren),
        .alu_asel(alu_asel), .alu_bsel(alu_bsel), .alu_op(alu_op), .result_sel(result_sel),
        .ximm_sel(ximm_sel), .retire(retire), .illegal_instr(illegal_instr),
        .retire_count(retire_count)
    );

    multicycle_controller #(.SUPPORT_JALR(1'b1), .SUPPORT_LUI(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .opcode(opcode_b), .mem_ready(ready_b),
        .mem_req(b_mem_req), .adr_sel(b_adr_sel), .ir_wren(b_ir_wren), .pc_update(b_pc_update),
        .branch(b_branch), .mem_wren(b_mem_wren), .regfile_wren(b_regfile_wren),
        .alu_asel(b_asel), .alu_bsel(b_bsel), .alu_op(b_alu_op), .result_sel(b_result_sel),
        .ximm_sel(b_ximm_sel), .retire(b_retire), .illegal_instr(b_illegal),
        .retire_count(b_count)
    );

    task automatic test_reset();
        rst_n = 1'b0; rst_b = 1'b0; mem_ready = 1'b0; ready_b = 1'b0;
        opcode = 7'd0; opcode_b = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs !== {XI, V_RST}) begin bad++; $display("FAIL reset_ctrl obs=%h exp=%h", obs, {XI, V_RST}); end
        total++;
        if (retire_count !== 32'd0) begin bad++; $display("FAIL reset_count obs=%0d exp=0", retire_count); end
        total++;
        if (illegal_instr !== 1'b0) begin bad++; $display("FAIL reset_illegal obs=%b exp=0", illegal_instr); end
        total++;
        if (obs_b !== V_RST || b_count !== 4'd0) begin
            bad++; $display("FAIL reset_b obs=%h cnt=%0d exp=%h cnt=0", obs_b, b_count, V_RST);
        end
        rst_n = 1'b1;
        #2;
        total++;
        if (obs !== {XI, V_FET_W}) begin bad++; $display("FAIL release_fetch obs=%h exp=%h", obs, {XI, V_FET_W}); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        logic [26:0] v [16];
        int rw = 0;
        int mw = 0;
        v = '{{OP_LW, 1'b1, XI, V_FET}, {OP_LW, 1'b1, XI, V_DEC}, {OP_LW, 1'b1, XI, V_MADR},
              {OP_LW, 1'b1, XI, V_MREQ}, {OP_LW, 1'b1, XI, V_MWB},
              {OP_SW, 1'b1, XS, V_FET}, {OP_SW, 1'b1, XS, V_DEC}, {OP_SW, 1'b1, XS, V_MADR},
              {OP_SW, 1'b1, XS, V_MWR},
              {OP_R, 1'b1, XI, V_FET}, {OP_R, 1'b1, XI, V_DEC}, {OP_R, 1'b1, XI, V_EXR},
              {OP_R, 1'b1, XI, V_ALUWB},
              {OP_BEQ, 1'b1, XB, V_FET}, {OP_BEQ, 1'b1, XB, V_DEC}, {OP_BEQ, 1'b1, XB, V_BEQ}};
        for (int i = 0; i < 16; i++) begin
            opcode = v[i][26:20]; mem_ready = v[i][19];
            #2;
            total++;
            if (obs !== v[i][18:0]) begin bad++; $display("FAIL stream cyc=%0d obs=%h exp=%h", i, obs, v[i][18:0]); end
            rw += int'(regfile_wren); mw += int'(mem_wren);
            @(posedge clk); #1;
        end
        total++;
        if (retire_count !== 32'd4) begin bad++; $display("FAIL stream_count obs=%0d exp=4", retire_count); end
        total++;
        if (rw != 2) begin bad++; $display("FAIL stream_regwr obs=%0d exp=2", rw); end
        total++;
        if (mw != 1) begin bad++; $display("FAIL stream_memwr obs=%0d exp=1", mw); end
    endtask

    task automatic test_stall();
        logic [26:0] v [15];
        v = '{{OP_LW, 1'b0, XI, V_FET_W}, {OP_LW, 1'b0, XI, V_FET_W}, {OP_LW, 1'b0, XI, V_FET_W},
              {OP_LW, 1'b1, XI, V_FET}, {OP_LW, 1'b1, XI, V_DEC}, {OP_LW, 1'b1, XI, V_MADR},
              {OP_LW, 1'b0, XI, V_MREQ}, {OP_LW, 1'b0, XI, V_MREQ}, {OP_LW, 1'b1, XI, V_MREQ},
              {OP_LW, 1'b0, XI, V_MWB},
              {OP_SW, 1'b1, XS, V_FET}, {OP_SW, 1'b0, XS, V_DEC}, {OP_SW, 1'b0, XS, V_MADR},
              {OP_SW, 1'b0, XS, V_MREQ}, {OP_SW, 1'b1, XS, V_MWR}};
        for (int i = 0; i < 15; i++) begin
            opcode = v[i][26:20]; mem_ready = v[i][19];
            #2;
            total++;
            if (obs !== v[i][18:0]) begin bad++; $display("FAIL stall cyc=%0d obs=%h exp=%h", i, obs, v[i][18:0]); end
            @(posedge clk); #1;
        end
        total++;
        if (retire_count !== 32'd6) begin bad++; $display("FAIL stall_count obs=%0d exp=6", retire_count); end
    endtask

    task automatic test_jal_jalr();
        logic [26:0] v [9];
        v = '{{OP_JAL, 1'b1, XJ, V_FET}, {OP_JAL, 1'b1, XJ, V_DEC}, {OP_JAL, 1'b1, XJ, V_JAL},
              {OP_JAL, 1'b1, XJ, V_ALUWB},
              {OP_JALR, 1'b1, XI, V_FET}, {OP_JALR, 1'b1, XI, V_DEC}, {OP_JALR, 1'b1, XI, V_MADR},
              {OP_JALR, 1'b1, XI, V_JAL}, {OP_JALR, 1'b1, XI, V_ALUWB}};
        for (int i = 0; i < 9; i++) begin
            opcode = v[i][26:20]; mem_ready = v[i][19];
            #2;
            total++;
            if (obs !== v[i][18:0]) begin bad++; $display("FAIL jal_jalr cyc=%0d obs=%h exp=%h", i, obs, v[i][18:0]); end
            @(posedge clk); #1;
        end
        total++;
        if (retire_count !== 32'd8) begin bad++; $display("FAIL jal_jalr_count obs=%0d exp=8", retire_count); end
    endtask

    task automatic test_trap();
        opcode = OP_SYS; mem_ready = 1'b1;
        #2;
        total++;
        if (obs !== {XI, V_FET}) begin bad++; $display("FAIL trap_fetch obs=%h exp=%h", obs, {XI, V_FET}); end
        @(posedge clk); #1;
        #1;
        total++;
        if (obs !== {XI, V_DEC} || illegal_instr !== 1'b0) begin
            bad++; $display("FAIL trap_decode obs=%h ill=%b exp=%h ill=0", obs, illegal_instr, {XI, V_DEC});
        end
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            total++;
            if (obs !== {XI, V_TRAP} || illegal_instr !== 1'b1) begin
                bad++; $display("FAIL trap_hold cyc=%0d obs=%h ill=%b exp=%h ill=1", i, obs, illegal_instr, {XI, V_TRAP});
            end
            @(posedge clk); #1;
        end
        total++;
        if (retire_count !== 32'd8) begin bad++; $display("FAIL trap_count obs=%0d exp=8", retire_count); end
        rst_n = 1'b0; opcode = 7'd0; mem_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (illegal_instr !== 1'b0 || retire_count !== 32'd0 || obs !== {XI, V_RST}) begin
            bad++; $display("FAIL trap_clear ill=%b cnt=%0d obs=%h exp ill=0 cnt=0 obs=%h",
                            illegal_instr, retire_count, obs, {XI, V_RST});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lui_disabled();
        rst_b = 1'b1; ready_b = 1'b1; opcode_b = OP_LUI;
        #2;
        total++;
        if (obs_b !== V_FET) begin bad++; $display("FAIL lui_fetch obs=%h exp=%h", obs_b, V_FET); end
        @(posedge clk); #3;
        total++;
        if (obs_b !== V_DEC || b_illegal !== 1'b0) begin
            bad++; $display("FAIL lui_decode obs=%h ill=%b exp=%h ill=0", obs_b, b_illegal, V_DEC);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #3;
            total++;
            if (obs_b !== V_TRAP || b_illegal !== 1'b1 || b_count !== 4'd0) begin
                bad++; $display("FAIL lui_trap cyc=%0d obs=%h ill=%b cnt=%0d exp=%h ill=1 cnt=0",
                                i, obs_b, b_illegal, b_count, V_TRAP);
            end
        end
        rst_b = 1'b0;
        @(posedge clk); #1;
        total++;
        if (b_illegal !== 1'b0) begin bad++; $display("FAIL lui_clear obs=%b exp=0", b_illegal); end
    endtask

    task automatic test_wrap();
        logic [15:0] rv [4];
        logic [3:0]  exp_cnt;
        rv = '{V_FET, V_DEC, V_EXR, V_ALUWB};
        rst_b = 1'b1; ready_b = 1'b1; opcode_b = OP_R;
        for (int n = 1; n <= 17; n++) begin
            for (int c = 0; c < 4; c++) begin
                #2;
                total++;
                if (obs_b !== rv[c]) begin bad++; $display("FAIL wrap_ctrl ins=%0d cyc=%0d obs=%h exp=%h", n, c, obs_b, rv[c]); end
                @(posedge clk); #1;
            end
            if (n >= 15) begin
                exp_cnt = (n == 15) ? 4'd15 : (n == 16) ? 4'd0 : 4'd1;
                total++;
                if (b_count !== exp_cnt) begin bad++; $display("FAIL wrap_count ins=%0d obs=%0d exp=%0d", n, b_count, exp_cnt); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_jal_jalr();
        test_trap();
        test_lui_disabled();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RISC-V core: a Moore FSM that steps each instruction through fetch/decode/execute/memory/writeback, driving datapath mux selects and write strobes. It sits beside the ALU decoder, replacing the single-cycle opcode decoder. It adds a ready handshake for variable-latency unified memory, optional `jalr`/`lui` support, sticky illegal-opcode trapping and a retired-instruction counter.

## Interface
Parameters:
- `SUPPORT_JALR`, 1: enables the `jalr` (1100111) path; 0 makes it illegal.
- `SUPPORT_LUI`, 1: enables the `lui` (0110111) path; 0 makes it illegal.
- `CNT_W`, 32: width of `retire_count`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `opcode`  in  7  instruction register bits [6:0].
- `mem_ready`  in  1  memory completes the current `mem_req` access this cycle.
- `mem_req`  out  1  memory access requested.
- `adr_sel`  out  1  0 = PC, 1 = ALU-out register.
- `ir_wren`  out  1  load the instruction register and old-PC register.
- `pc_update`  out  1  unconditional PC write.
- `branch`  out  1  PC write if ALU zero.
- `mem_wren`  out  1  memory write.
- `regfile_wren`  out  1  register file write.
- `alu_asel`  out  2  00 PC, 01 old PC, 10 rs1, 11 zero.
- `alu_bsel`  out  2  00 rs2, 01 ximm, 10 constant 4.
- `alu_op`  out  2  00 add, 01 subtract/compare, 10 funct-decoded.
- `result_sel`  out  2  00 ALU-out register, 01 read data, 10 ALU result.
- `ximm_sel`  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- `retire`  out  1  one-cycle pulse as an instruction completes.
- `illegal_instr`  out  1  sticky trap flag.
- `retire_count`  out  CNT_W  instructions retired.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, JAL, BEQ, JALR_ADR, JALR, LUI, TRAP.
- Unlisted outputs are 0 in every state.

Per-state outputs and transitions:
- FETCH:
  - Outputs: mem_req=1, adr_sel=0, asel=00, bsel=10, alu_op=00, result_sel=10.
  - ir_wren=pc_update=mem_ready.
  - Stay while !mem_ready; else go to DECODE.
- DECODE:
  - Outputs: asel=01, bsel=01, alu_op=00 (precomputes the branch/jal target).
  - Next state by opcode:
    - lw (0000011) or sw (0100011) → MEMADR.
    - R (0110011) → EXEC_R.
    - I (0010011) → EXEC_I.
    - jal (1101111) → JAL.
    - beq (1100011) → BEQ.
    - jalr → JALR_ADR, when enabled.
    - lui → LUI, when enabled.
    - anything else → TRAP.
- MEMADR:
  - Outputs: asel=10, bsel=01, alu_op=00.
  - → MEMREAD if lw, MEMWRITE if sw.
- MEMREAD:
  - Outputs: mem_req=1, adr_sel=1.
  - Hold until mem_ready, then → MEMWB.
- MEMWB: result_sel=01, regfile_wren=1 → FETCH.
- MEMWRITE:
  - Outputs: mem_req=1, adr_sel=1, mem_wren=mem_ready.
  - Hold until mem_ready, then → FETCH.
- EXEC_R: asel=10, bsel=00, alu_op=10 → ALUWB.
- EXEC_I: asel=10, bsel=01, alu_op=10 → ALUWB.
- ALUWB: result_sel=00, regfile_wren=1 → FETCH.
- JAL: asel=01, bsel=10, alu_op=00, result_sel=00, pc_update=1 → ALUWB (rd = old PC+4).
- BEQ: asel=10, bsel=00, alu_op=01, result_sel=00, branch=1 → FETCH.
- JALR_ADR: asel=10, bsel=01, alu_op=00 → JALR.
- JALR: same outputs as JAL (PC ← rs1+imm) → ALUWB.
- LUI: asel=11, bsel=01, alu_op=00 → ALUWB.
- TRAP: all strobes 0; illegal_instr=1; absorbing until reset.

Opcode-driven outputs:
- `ximm_sel` is combinational from `opcode` in every state:
  - I for lw, I-type and jalr.
  - S for sw.
  - B for beq.
  - J for jal.
  - U for lui.
  - 000 otherwise.
- `opcode` is only meaningful from DECODE onward. The IR holds it stable until the next FETCH ir_wren.

Retirement:
- `retire` = 1 whenever the next state is FETCH and the current state is not FETCH.
- `retire_count` increments on each `retire`, wrapping modulo 2^CNT_W.

## Timing
- Reset: while rst_n=0 at a rising edge, the state goes to FETCH, retire_count to 0 and illegal_instr to 0.
- While rst_n is low, all strobes and `retire` are forced to 0 combinationally. The first mem_req appears in the cycle after rst_n is seen high.
- Reset mid-instruction abandons the instruction with no write; TRAP is also left only by reset.
- Latency with zero memory wait (mem_ready tied 1):

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R, I, jal, lui | 4 |
  | beq | 3 |
  | jalr | 5 |

  Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_req is held stable and its address select unchanged until mem_ready. mem_ready while mem_req=0 is ignored.
- illegal_instr rises in the cycle after DECODE sees an illegal opcode; retire stays 0 for that instruction.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the opcode constants;
  - the state enum;
  - the asel/bsel/result_sel/alu_op/ximm_sel encodings;
  - the parameter defaults.
- One combinational sub-module, `ctrl_opcode_classifier`, maps opcode plus the SUPPORT_* parameters to an instruction class and `ximm_sel`.
- The FSM, counter and output decode live in the top module.

## Test plan
1. Reset with rst_n=0 for 2 cycles, then release:
   - before release, all strobes 0 and retire_count=0;
   - first post-release cycle is FETCH with mem_req=1, adr_sel=0.
2. mem_ready=1, opcode stream lw, sw, R (0110011), beq:
   - state sequences match Operation;
   - cycle counts 5/4/4/3;
   - retire_count=4;
   - exactly one regfile_wren each for lw and R; one mem_wren for sw.
3. lw with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD:
   - takes 10 cycles;
   - ir_wren and pc_update fire only on the ready cycle;
   - mem_req and adr_sel stay stable while waiting.
4. jal then jalr (SUPPORT_JALR=1):
   - JAL gives pc_update=1 with asel=01, bsel=10;
   - jalr passes JALR_ADR→JALR→ALUWB;
   - ximm_sel is 011 for jal and 000 for jalr.
5. Opcode 1110011, then lui with SUPPORT_LUI=0:
   - TRAP is entered after DECODE and illegal_instr=1;
   - no strobes for 20 cycles and retire_count unchanged;
   - rst_n low clears the trap.
6. Counter wrap: CNT_W=4, 17 R-type instructions → retire_count=1.
